// File: rtl/mul_div_unit_if.sv
// Operand, HI/LO write and result signals between the control unit and mul_div_unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wd,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wd,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Operates on magnitudes for WIDTH cycles, then applies sign fixup in one FIX cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rs_neg_q, rs_neg_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rs_raw_q, rs_raw_d;
  logic [W2-1:0]    work_q, work_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             sgn_c;
  logic [WIDTH-1:0] rs_mag_c, rt_mag_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   div_diff_c;
  logic [W2-1:0]    prod_fix_c;
  logic [WIDTH-1:0] quot_fix_c, rem_fix_c;

  // op[0]=0 selects the signed variants; magnitudes of the most negative value stay exact
  assign sgn_c    = ~bus.op[0];
  assign rs_mag_c = (sgn_c && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign rt_mag_c = (sgn_c && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

  // work_q holds {acc, multiplier} for mul and {remainder, dividend/quotient} for div
  assign mul_sum_c  = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, b_q} : '0);
  assign div_diff_c = work_q[W2-1:WIDTH-1] - {1'b0, b_q};

  assign prod_fix_c = neg_q    ? -work_q : work_q;
  assign quot_fix_c = neg_q    ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  assign rem_fix_c  = rs_neg_q ? -work_q[W2-1:WIDTH] : work_q[W2-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      b_q      <= '0;
      rs_raw_q <= '0;
      work_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rs_neg_q <= rs_neg_d;
      b_q      <= b_d;
      rs_raw_q <= rs_raw_d;
      work_q   <= work_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rs_neg_d = rs_neg_q;
    b_d      = b_q;
    rs_raw_d = rs_raw_q;
    work_d   = work_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          neg_d    = sgn_c & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
          rs_neg_d = sgn_c & bus.rs_val[WIDTH-1];
          b_d      = rt_mag_c;
          rs_raw_d = bus.rs_val;
          work_d   = {WIDTH'(0), rs_mag_c};
          count_d  = '0;
          dz_d     = 1'b0;
          state_d  = ST_CALC;
        end else begin
          if (bus.hi_we) hi_d = bus.wd;
          if (bus.lo_we) lo_d = bus.wd;
        end
      end
      ST_CALC: begin
        count_d = count_q + CW'(1);
        if (!is_div_q) begin
          work_d = {mul_sum_c, work_q[WIDTH-1:1]};
        end else if (!div_diff_c[WIDTH]) begin
          work_d = {div_diff_c[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        end else begin
          work_d = {work_q[W2-2:0], 1'b0};
        end
        if (count_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix_c;
        end else if (b_q == '0) begin
          lo_d = '1;
          hi_d = rs_raw_q;
          dz_d = 1'b1;
        end else begin
          lo_d = quot_fix_c;
          hi_d = rem_fix_c;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: 64-bit arithmetic reference, monitor pops on done.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32), .CW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    e.dz = 1'b0;
    case (op)
      2'b00: begin sp = sa * sb; e.hi = sp[63:32]; e.lo = sp[31:0]; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
        end else if (op == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_hi", bus.hi, e.hi);
        check("res_lo", bus.lo, e.lo);
        check("res_dz", 32'(bus.dz), 32'(e.dz));
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
    int n = 0;
    while (bus.busy && n < 100) begin cyc(1); n++; end
    if (bus.busy) check("issue_timeout", 32'd1, 32'd0);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    if (track) exp_q.push_back(model(op, a, b));
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 200) begin cyc(1); n++; end
    cyc(1);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = '0;
    cyc(3);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dz",   32'(bus.dz),   32'd0);
    check("rst_hi",   bus.hi, 32'd0);
    check("rst_lo",   bus.lo, 32'd0);

    // Latency: busy in cycles 1..33, done with busy low in cycle 34
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int c = 1; c <= 33; c++) begin
      check("lat_busy", 32'(bus.busy), 32'd1);
      check("lat_nodone", 32'(bus.done), 32'd0);
      cyc(1);
    end
    check("lat_done", 32'(bus.done), 32'd1);
    check("lat_idle", 32'(bus.busy), 32'd0);
    check("lat_hi", bus.hi, 32'hFFFF_FFFE);
    check("lat_lo", bus.lo, 32'h0000_0001);

    // Directed corner cases, issued back-to-back
    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    issue(2'b11, 32'd100, 32'd7, 1'b1);
    issue(2'b11, 32'h0000_0123, 32'd0, 1'b1);
    issue(2'b01, 32'd2, 32'd3, 1'b1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'b10, 32'hFFFF_FF00, 32'd0, 1'b1);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
    drain();

    // MTHI/MTLO in idle, dropped when coincident with start, ignored while busy
    bus.hi_we = 1'b1; bus.wd = 32'hAAAA_0000; cyc(1); bus.hi_we = 1'b0;
    check("mthi", bus.hi, 32'hAAAA_0000);
    bus.lo_we = 1'b1; bus.wd = 32'h0000_5555; cyc(1); bus.lo_we = 1'b0;
    check("mtlo", bus.lo, 32'h0000_5555);
    bus.hi_we = 1'b1; bus.wd = 32'h0000_0077;
    issue(2'b00, 32'h0001_0003, 32'hFFFF_0005, 1'b1);
    bus.hi_we = 1'b0;
    check("start_wins", bus.hi, 32'hAAAA_0000);
    cyc(8);
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_val = 32'd9; bus.rt_val = 32'd0;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'h0000_0055;
    cyc(1);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("busy_hold_hi", bus.hi, 32'hAAAA_0000);
    check("busy_hold_lo", bus.lo, 32'h0000_5555);
    check("busy_still", 32'(bus.busy), 32'd1);
    drain();

    // Randomized ops with occasional idle MTHI/MTLO writes
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drain();
        w = $urandom;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = w;
        cyc(1);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("rand_mt_hi", bus.hi, w);
        check("rand_mt_lo", bus.lo, w);
      end
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b1);
    end
    drain();

    // Reset mid-divide aborts with cleared hi/lo and no done pulse
    issue(2'b10, 32'h1234_5678, 32'h0000_0013, 1'b0);
    cyc(14);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    cyc(40);
    check("abort_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
